// File: rtl/register_file.sv
// 32x32 register file with power-on clear sweep, write-through bypass on both
// read ports, an unbypassed debug read port and a saturating write counter.
module register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  read_reg1,
  input  logic [4:0]  read_reg2,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2,
  input  logic [4:0]  write_reg,
  input  logic [31:0] write_data,
  input  logic        RegWrite,
  output logic        ready,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic [15:0] write_count
);

  typedef enum logic {CLEAR, READY} state_t;

  state_t      state;
  logic [4:0]  clr_idx;
  logic [31:0] regs [32];
  logic        wr_en;
  logic        rd_ok;

  assign wr_en = (state == READY) && RegWrite && (write_reg != '0);
  assign rd_ok = ready && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      clr_idx     <= '0;
      ready       <= 1'b0;
      write_count <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + 5'd1;
          if (clr_idx == 5'd31) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        READY: begin
          if (wr_en && (write_count != '1))
            write_count <= write_count + 16'd1;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Array has no reset; the sweep zeroes it one entry per cycle instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR)
        regs[clr_idx] <= '0;
      else if (wr_en)
        regs[write_reg] <= write_data;
    end
  end

  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    dbg_data   = '0;
    if (rd_ok) begin
      if (read_reg1 != '0)
        read_data1 = (wr_en && write_reg == read_reg1) ? write_data : regs[read_reg1];
      if (read_reg2 != '0)
        read_data2 = (wr_en && write_reg == read_reg2) ? write_data : regs[read_reg2];
      if (dbg_addr != '0)
        dbg_data = regs[dbg_addr];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: clear sweep, write/read,
// bypass, register 0, reset during operation and mid-sweep, counter saturation.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  read_reg1, read_reg2, write_reg, dbg_addr;
  logic [31:0] write_data;
  logic        RegWrite;
  logic [31:0] read_data1, read_data2, dbg_data;
  logic        ready;
  logic [15:0] write_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  register_file dut (
    .clk(clk), .rst(rst),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2),
    .write_reg(write_reg), .write_data(write_data), .RegWrite(RegWrite),
    .ready(ready), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .write_count(write_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_and_check_ready(input logic [4:0] probe);
    read_reg1 = probe;
    for (int i = 1; i <= 31; i++) begin
      step();
      check("sweep_ready_low", {31'd0, ready}, 32'd0);
      check("sweep_read_zero", read_data1, 32'h0);
      check("sweep_count_hold", {16'd0, write_count}, 32'd0);
    end
    step();
    check("sweep_ready_high", {31'd0, ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; RegWrite = 1'b0; write_reg = '0; write_data = '0;
    read_reg1 = 5'd5; read_reg2 = 5'd6; dbg_addr = 5'd7;

    repeat (3) step();
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_count", {16'd0, write_count}, 32'd0);
    check("rst_rd1", read_data1, 32'h0);
    check("rst_rd2", read_data2, 32'h0);
    check("rst_dbg", dbg_data, 32'h0);

    // Writes during the sweep must be ignored and not counted
    rst = 1'b0; RegWrite = 1'b1; write_reg = 5'd2; write_data = 32'hCAFEF00D;
    sweep_and_check_ready(5'd2);
    RegWrite = 1'b0;
    check("post_sweep_count", {16'd0, write_count}, 32'd0);

    for (int a = 0; a < 32; a++) begin
      dbg_addr = a[4:0];
      #1;
      check("clear_dbg", dbg_data, 32'h0);
    end

    write_reg = 5'd5; write_data = 32'hDEADBEEF; RegWrite = 1'b1;
    step();
    RegWrite = 1'b0; read_reg1 = 5'd5; dbg_addr = 5'd5;
    #1;
    check("wr_r5_rd1", read_data1, 32'hDEADBEEF);
    check("wr_r5_dbg", dbg_data, 32'hDEADBEEF);
    check("wr_r5_count", {16'd0, write_count}, 32'd1);

    write_reg = 5'd7; write_data = 32'h12345678; RegWrite = 1'b1;
    read_reg1 = 5'd7; read_reg2 = 5'd7; dbg_addr = 5'd7;
    #1;
    check("byp_rd1", read_data1, 32'h12345678);
    check("byp_rd2", read_data2, 32'h12345678);
    check("byp_dbg_old", dbg_data, 32'h0);
    step();
    RegWrite = 1'b0;
    #1;
    check("byp_dbg_new", dbg_data, 32'h12345678);
    check("byp_count", {16'd0, write_count}, 32'd2);

    write_reg = 5'd5; write_data = 32'h11112222; RegWrite = 1'b1;
    read_reg1 = 5'd7; read_reg2 = 5'd5;
    #1;
    check("byp_split_rd1", read_data1, 32'h12345678);
    check("byp_split_rd2", read_data2, 32'h11112222);
    step();
    RegWrite = 1'b0;
    #1;
    check("byp_split_count", {16'd0, write_count}, 32'd3);

    write_reg = 5'd0; write_data = 32'hFFFFFFFF; RegWrite = 1'b1;
    read_reg1 = 5'd0; read_reg2 = 5'd0; dbg_addr = 5'd0;
    #1;
    check("r0_rd1_byp", read_data1, 32'h0);
    check("r0_rd2_byp", read_data2, 32'h0);
    step();
    RegWrite = 1'b0;
    #1;
    check("r0_dbg", dbg_data, 32'h0);
    check("r0_count", {16'd0, write_count}, 32'd3);

    write_reg = 5'd3; write_data = 32'hA5A5A5A5; RegWrite = 1'b1;
    step();
    read_reg1 = 5'd3; RegWrite = 1'b0;
    #1;
    check("r3_set", read_data1, 32'hA5A5A5A5);
    check("r3_count", {16'd0, write_count}, 32'd4);

    // Reset coincident with a write to r4: write dropped, state cleared
    rst = 1'b1; write_reg = 5'd4; write_data = 32'h44444444; RegWrite = 1'b1;
    step();
    RegWrite = 1'b0;
    check("rst_op_ready", {31'd0, ready}, 32'd0);
    check("rst_op_count", {16'd0, write_count}, 32'd0);
    check("rst_op_rd1", read_data1, 32'h0);

    // Partial sweep then reset again; sweep must restart from index 0
    rst = 1'b0;
    repeat (10) step();
    check("mid_ready", {31'd0, ready}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sweep_and_check_ready(5'd3);
    read_reg1 = 5'd3; read_reg2 = 5'd4; dbg_addr = 5'd5;
    #1;
    check("after_rst_r3", read_data1, 32'h0);
    check("after_rst_r4", read_data2, 32'h0);
    check("after_rst_r5", dbg_data, 32'h0);
    check("after_rst_count", {16'd0, write_count}, 32'd0);

    write_reg = 5'd1; RegWrite = 1'b1; dbg_addr = 5'd1;
    for (int i = 0; i < 65540; i++) begin
      write_data = i;
      step();
      if (i == 65533)
        check("sat_minus1", {16'd0, write_count}, 32'h0000FFFE);
      if (i == 65534)
        check("sat_reach", {16'd0, write_count}, 32'h0000FFFF);
    end
    RegWrite = 1'b0;
    #1;
    check("sat_final", {16'd0, write_count}, 32'h0000FFFF);
    check("sat_r1_data", dbg_data, 32'd65539);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-002 The block SHALL have these read ports:
- read_reg1  in  5  read address, port 1 (rs).
- read_reg2  in  5  read address, port 2 (rt).
- read_data1  out  32  read data, port 1.
- read_data2  out  32  read data, port 2.
REQ-003 The block SHALL have these write ports:
- write_reg  in  5  write address, driven by the RegDst multiplexer output.
- write_data  in  32  write-back data.
- RegWrite  in  1  write enable from the Control Unit.
REQ-004 The block SHALL have these status and debug ports:
- ready  out  1  1 once the register array has been fully cleared.
- dbg_addr  in  5  debug read address.
- dbg_data  out  32  debug read data.
- write_count  out  16  number of accepted writes.

Function
REQ-005 Storage SHALL be 32 registers of 32 bits each; register 0 SHALL always read as 32'h0 and SHALL never be written.
REQ-006 State machine states SHALL be CLEAR and READY.
REQ-007 On any rising edge with rst=1, the block SHALL:
- enter CLEAR;
- set the clear index to 0, ready=0 and write_count=0;
- leave array contents untouched on that edge.
REQ-008 In CLEAR, each rising edge with rst=0 SHALL write 32'h0 to register[index] and increment the index.
REQ-009 On the CLEAR edge where index=31, the block SHALL move to READY and set ready=1, so that ready rises exactly 32 non-reset edges after rst deasserts.
REQ-010 While not ready:
- RegWrite SHALL be ignored;
- read_data1, read_data2 and dbg_data SHALL be 32'h0;
- write_count SHALL hold.
REQ-011 In READY, a write SHALL be accepted when RegWrite=1 and write_reg!=0; register[write_reg] SHALL take write_data at that rising edge.
REQ-012 Reads SHALL be combinational, with zero latency from read_regN to read_dataN.
REQ-013 Write-through bypass: when ready=1, RegWrite=1, write_reg!=0 and write_reg==read_regN, read_dataN SHALL equal write_data in the same cycle.
- Both ports SHALL bypass independently and simultaneously.
REQ-014 read_regN=0 SHALL return 32'h0 regardless of any bypass condition.
REQ-015 dbg_data SHALL be register[dbg_addr] with no bypass; register 0 SHALL read as 0.
REQ-016 write_count SHALL increment by 1 per accepted write and SHALL saturate at 16'hFFFF.
- A write attempt to register 0 SHALL NOT count.
REQ-017 rst asserted in READY SHALL behave as REQ-007.
- A write presented on the same edge SHALL be dropped and not counted.
- Old register values SHALL persist until overwritten by the new clear sweep, but SHALL never be visible because reads return 0 while not ready.
REQ-018 rst reasserted mid-CLEAR SHALL restart the sweep from index 0.
REQ-019 All widths SHALL be fixed as listed; no arithmetic SHALL be performed on data.

Reset
REQ-020 Output values while rst=1 and after reset until ready:
- ready=0, write_count=0;
- read_data1, read_data2 and dbg_data = 32'h0.
REQ-021 Array contents SHALL be 32'h0 for every register once ready=1, independent of any power-up value.

Verification
REQ-022 Reset sweep: hold rst=1 for 3 cycles, then release -> ready=0 for 31 edges and 1 after the 32nd; dbg_addr sweep 0..31 -> all reads return 32'h0.
REQ-023 Write then read: write 32'hDEADBEEF to r5; on the next cycle read_reg1=5 -> read_data1=32'hDEADBEEF; write_count=1.
REQ-024 Bypass: with RegWrite=1, write_reg=7, write_data=32'h12345678 and read_reg1=read_reg2=7 -> both read_data=32'h12345678 in the same cycle; dbg_addr=7 -> old value 32'h0 until the edge.
REQ-025 Register 0: write 32'hFFFFFFFF to r0 -> read_data1 (read_reg1=0)=32'h0, dbg_data=0, write_count unchanged.
REQ-026 Reset mid-operation: with r3=32'hA5A5A5A5, assert rst together with a write to r4 -> ready=0 and reads=0 during the sweep; after ready, r3=0, r4=0, write_count=0.
REQ-027 Saturation: perform 65540 writes to r1 -> write_count=16'hFFFF.
